fetch_ctrl: RTL

Instruction-fetch front end that sits directly upstream of the instruction cache and feeds decode. It generates the fetch PC that drives the icache `pc` input. It pairs each registered icache instruction, returned one cycle later, with the PC that produced it. The pair is buffered in a small FIFO and presented to decode over a valid/ready handshake. A redirect from the back end (branch, jump or trap) flushes all in-flight and buffered work and restarts fetch at the new PC.

---
 rtl/fetch_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: drives the icache address, pairs each returned word
// with its PC, buffers the pairs in a small FIFO and hands them to decode.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] icache_pc,
  input  logic [31:0] icache_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [63:0]      fetch_pc;
  logic             inflight_valid;
  logic [63:0]      inflight_pc;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;

  // Credit counts the word still in flight, so the FIFO can never overflow on push.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_valid};
  assign issue     = occupancy < DEPTH_W;
  assign push      = inflight_valid;
  assign pop       = out_valid && out_ready;

  assign icache_pc = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = mem[rd_ptr].pc;
  assign out_instr = mem[rd_ptr].instr;

  // Redirect outranks issue/push/pop; reset outranks redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= {redirect_pc[63:2], 2'b00};
      inflight_valid <= 1'b0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 64'd4;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage carries no reset; count gates out_valid, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      mem[wr_ptr] <= '{pc: inflight_pc, instr: icache_instr};
    end
  end

endmodule
